// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 32 x 32-bit
// register file with same-cycle read bypass, owns the PC register and counts
// committed register writes.
module wb_regfile #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Jump,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic [27:0] in_JumpAddress,
  input  logic [31:0] in_AddFour,
  input  logic [31:0] in_Adder,
  input  logic        in_ANDGate,
  input  logic [31:0] in_ReadData,
  input  logic [31:0] in_ALU,
  input  logic [4:0]  in_WriteRegister,
  input  logic        in_Stall,
  input  logic [4:0]  in_ReadRegister1,
  input  logic [4:0]  in_ReadRegister2,
  output logic [31:0] out_ReadData1,
  output logic [31:0] out_ReadData2,
  output logic [31:0] out_WriteData,
  output logic [31:0] out_PC,
  output logic [31:0] out_WBCount
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] pc_q, pc_d;
  logic [31:0] wb_count_q, wb_count_d;
  logic        commit;

  // Writeback value select and commit qualification (reset drops the write)
  always_comb begin
    out_WriteData = in_MemtoReg ? in_ReadData : in_ALU;
    commit        = in_RegWrite && (in_WriteRegister != 5'd0) && !reset;
  end

  // Register array and counter next state
  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (commit) begin
      regs_d[in_WriteRegister] = out_WriteData;
      wb_count_d               = wb_count_q + 32'd1;
    end
  end

  // Next-PC priority mux: stall, jump, branch, sequential
  always_comb begin
    pc_d = in_AddFour;
    if (in_Stall) begin
      pc_d = pc_q;
    end else if (in_Jump) begin
      pc_d = {in_AddFour[31:28], in_JumpAddress};
    end else if (in_ANDGate) begin
      pc_d = in_Adder;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      pc_q       <= RESET_PC;
      wb_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pc_q       <= pc_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Read ports: register 0 is zero, in-flight commit bypasses the array
  always_comb begin
    if (in_ReadRegister1 == 5'd0) begin
      out_ReadData1 = 32'd0;
    end else if (commit && (in_ReadRegister1 == in_WriteRegister)) begin
      out_ReadData1 = out_WriteData;
    end else begin
      out_ReadData1 = regs_q[in_ReadRegister1];
    end

    if (in_ReadRegister2 == 5'd0) begin
      out_ReadData2 = 32'd0;
    end else if (commit && (in_ReadRegister2 == in_WriteRegister)) begin
      out_ReadData2 = out_WriteData;
    end else begin
      out_ReadData2 = regs_q[in_ReadRegister2];
    end
  end

  assign out_PC      = pc_q;
  assign out_WBCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected values tagged with
// the cycle they apply to; a monitor compares them at the falling edge.
module tb_wb_regfile;

  localparam logic [31:0] RstPc = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_Jump, in_MemtoReg, in_RegWrite, in_ANDGate, in_Stall;
  logic [27:0] in_JumpAddress;
  logic [31:0] in_AddFour, in_Adder, in_ReadData, in_ALU;
  logic [4:0]  in_WriteRegister, in_ReadRegister1, in_ReadRegister2;
  logic [31:0] out_ReadData1, out_ReadData2, out_WriteData, out_PC, out_WBCount;

  wb_regfile #(.RESET_PC(RstPc)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_Jump          (in_Jump),
    .in_MemtoReg      (in_MemtoReg),
    .in_RegWrite      (in_RegWrite),
    .in_JumpAddress   (in_JumpAddress),
    .in_AddFour       (in_AddFour),
    .in_Adder         (in_Adder),
    .in_ANDGate       (in_ANDGate),
    .in_ReadData      (in_ReadData),
    .in_ALU           (in_ALU),
    .in_WriteRegister (in_WriteRegister),
    .in_Stall         (in_Stall),
    .in_ReadRegister1 (in_ReadRegister1),
    .in_ReadRegister2 (in_ReadRegister2),
    .out_ReadData1    (out_ReadData1),
    .out_ReadData2    (out_ReadData2),
    .out_WriteData    (out_WriteData),
    .out_PC           (out_PC),
    .out_WBCount      (out_WBCount)
  );

  always #5 clk = ~clk;

  typedef enum int {SigRd1, SigRd2, SigWd, SigPc, SigCnt} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_val(input sig_e sig, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc;
    c.sig  = sig;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
  endtask

  // Monitor: pop every entry tagged for the current cycle and compare
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      chk_t        c;
      logic [31:0] act;
      c = sb_q.pop_front();
      case (c.sig)
        SigRd1:  act = out_ReadData1;
        SigRd2:  act = out_ReadData2;
        SigWd:   act = out_WriteData;
        SigPc:   act = out_PC;
        default: act = out_WBCount;
      endcase
      n_cmp++;
      if (act !== c.exp || c.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", c.name, cyc, act, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {in_Jump, in_MemtoReg, in_RegWrite, in_ANDGate, in_Stall} = '0;
    in_JumpAddress   = '0;
    in_AddFour       = '0;
    in_Adder         = '0;
    in_ReadData      = '0;
    in_ALU           = '0;
    in_WriteRegister = '0;
    in_ReadRegister1 = '0;
    in_ReadRegister2 = '0;
    step();
    reset    = 1'b0;
    in_Stall = 1'b1;

    // Reset state: every register reads zero, PC held at reset value
    for (int a = 0; a < 32; a++) begin
      in_ReadRegister1 = 5'(a);
      in_ReadRegister2 = 5'(31 - a);
      expect_val(SigRd1, 32'd0, "reset_rd1");
      expect_val(SigRd2, 32'd0, "reset_rd2");
      if (a == 0 || a == 31) begin
        expect_val(SigPc, RstPc, "reset_pc");
        expect_val(SigCnt, 32'd0, "reset_cnt");
      end
      step();
    end

    // ALU write to r5 with same-cycle bypass
    in_RegWrite = 1'b1; in_ALU = 32'hDEAD_BEEF; in_WriteRegister = 5'd5;
    in_ReadRegister1 = 5'd5; in_ReadRegister2 = 5'd6;
    expect_val(SigRd1, 32'hDEAD_BEEF, "bypass_alu_rd1");
    expect_val(SigRd2, 32'd0, "no_bypass_rd2");
    expect_val(SigWd, 32'hDEAD_BEEF, "wd_alu");
    expect_val(SigCnt, 32'd0, "cnt_before_commit");
    step();
    in_RegWrite = 1'b0;
    expect_val(SigRd1, 32'hDEAD_BEEF, "array_alu_rd1");
    expect_val(SigCnt, 32'd1, "cnt_after_first");
    step();

    // Load-data write to r5, both ports bypass
    in_RegWrite = 1'b1; in_MemtoReg = 1'b1; in_ReadData = 32'h1234_5678; in_ALU = 32'h0BAD_0BAD;
    in_ReadRegister2 = 5'd5;
    expect_val(SigRd1, 32'h1234_5678, "bypass_load_rd1");
    expect_val(SigRd2, 32'h1234_5678, "bypass_load_rd2");
    expect_val(SigWd, 32'h1234_5678, "wd_load");
    step();
    in_RegWrite = 1'b0;
    expect_val(SigRd2, 32'h1234_5678, "array_load_rd2");
    expect_val(SigCnt, 32'd2, "cnt_after_second");
    step();

    // Write to r0 is discarded and not counted
    in_RegWrite = 1'b1; in_MemtoReg = 1'b0; in_ALU = 32'hFFFF_FFFF; in_WriteRegister = 5'd0;
    in_ReadRegister1 = 5'd0; in_ReadRegister2 = 5'd0;
    expect_val(SigRd1, 32'd0, "r0_bypass_rd1");
    expect_val(SigRd2, 32'd0, "r0_bypass_rd2");
    expect_val(SigWd, 32'hFFFF_FFFF, "wd_r0");
    step();
    in_RegWrite = 1'b0;
    expect_val(SigRd1, 32'd0, "r0_array_rd1");
    expect_val(SigCnt, 32'd2, "cnt_r0_unchanged");
    step();

    // Port 2 bypasses while port 1 reads the array
    in_RegWrite = 1'b1; in_ALU = 32'h0000_0033; in_WriteRegister = 5'd3;
    in_ReadRegister1 = 5'd5; in_ReadRegister2 = 5'd3;
    expect_val(SigRd1, 32'h1234_5678, "split_rd1_array");
    expect_val(SigRd2, 32'h0000_0033, "split_rd2_bypass");
    step();
    in_RegWrite = 1'b0;
    expect_val(SigCnt, 32'd3, "cnt_after_third");
    step();

    // PC select
    in_Stall = 1'b0;
    in_AddFour = 32'hA000_0010; in_Adder = 32'h0000_0400; in_JumpAddress = 28'h000_0800;
    step();
    expect_val(SigPc, 32'hA000_0010, "pc_seq");
    in_ANDGate = 1'b1;
    step();
    expect_val(SigPc, 32'h0000_0400, "pc_branch");
    in_Jump = 1'b1;
    step();
    expect_val(SigPc, 32'hA000_0800, "pc_jump_over_branch");
    // Stall with concurrent write to r7
    in_Jump = 1'b0; in_ANDGate = 1'b0; in_Stall = 1'b1;
    in_RegWrite = 1'b1; in_ALU = 32'h0000_0077; in_WriteRegister = 5'd7;
    step();
    in_RegWrite = 1'b0; in_ReadRegister1 = 5'd7;
    expect_val(SigPc, 32'hA000_0800, "pc_stall_hold1");
    expect_val(SigRd1, 32'h0000_0077, "stall_write_commits");
    expect_val(SigCnt, 32'd4, "stall_write_counted");
    step();
    expect_val(SigPc, 32'hA000_0800, "pc_stall_hold2");
    in_Stall = 1'b0;
    step();
    expect_val(SigPc, 32'hA000_0010, "pc_after_stall");

    // Reset mid-stream with a write to r9 in the same cycle
    reset = 1'b1; in_RegWrite = 1'b1; in_ALU = 32'h0000_0099; in_WriteRegister = 5'd9;
    in_ReadRegister1 = 5'd9; in_ReadRegister2 = 5'd5;
    expect_val(SigRd1, 32'd0, "reset_write_no_bypass");
    expect_val(SigWd, 32'h0000_0099, "wd_during_reset");
    step();
    reset = 1'b0; in_RegWrite = 1'b0; in_Stall = 1'b1;
    expect_val(SigRd1, 32'd0, "reset_r9_cleared");
    expect_val(SigRd2, 32'd0, "reset_r5_cleared");
    expect_val(SigCnt, 32'd0, "reset_cnt_cleared");
    expect_val(SigPc, RstPc, "reset_pc_mid");
    step();

    // Counter wrap: preload all-ones, then commit once more
    force dut.wb_count_q = 32'hFFFF_FFFF;
    in_RegWrite = 1'b1; in_ALU = 32'h0000_0001; in_WriteRegister = 5'd1;
    expect_val(SigCnt, 32'hFFFF_FFFF, "cnt_preload");
    @(negedge clk);
    #1;
    release dut.wb_count_q;
    step();
    in_RegWrite = 1'b0; in_ReadRegister1 = 5'd1;
    expect_val(SigCnt, 32'd0, "cnt_wrap");
    expect_val(SigRd1, 32'h0000_0001, "wrap_write_committed");
    step();
    step();

    if (sb_q.size() != 0) begin
      n_bad += sb_q.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
